// File: rtl/decode_ctrl_stage_if.sv
// ID-stage bus between IF/ID and the decode control stage.
// The master drives instructions and pipeline control; the slave returns the control word.
interface decode_ctrl_stage_if #(
  parameter int unsigned INSTR_W  = 16,
  parameter int unsigned ALU_OP_W = 3
);
  logic [INSTR_W-1:0]  instr_in;
  logic                instr_valid;
  logic                stall_in;
  logic                flush;
  logic                fetch_stall;
  logic                ctrl_valid;
  logic                data_reg;
  logic                call;
  logic                rtrn;
  logic                branch;
  logic                mem_to_reg;
  logic                reg_to_mem;
  logic                alu_src;
  logic                sign_ext_sel;
  logic                reg_rt_src;
  logic                reg_write;
  logic [ALU_OP_W-1:0] alu_op;
  logic                seq_last;
  logic                halted;

  modport master (
    output instr_in, instr_valid, stall_in, flush,
    input  fetch_stall, ctrl_valid, data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
           alu_src, sign_ext_sel, reg_rt_src, reg_write, alu_op, seq_last, halted
  );

  modport slave (
    input  instr_in, instr_valid, stall_in, flush,
    output fetch_stall, ctrl_valid, data_reg, call, rtrn, branch, mem_to_reg, reg_to_mem,
           alu_src, sign_ext_sel, reg_rt_src, reg_write, alu_op, seq_last, halted
  );
endinterface

// File: rtl/decode_ctrl_stage.sv
// WISC decode control stage: opcode -> registered ID/EX control word, with CALL/RET sequencing.
// Optional halt-on-ERR behaviour is enabled by defining DECODE_HALT_ON_ERR_EN.
module decode_ctrl_stage #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned ALU_OP_W   = 3,
  parameter int unsigned SEQ_CYCLES = 2
) (
  input logic                clk,
  input logic                rst,
  decode_ctrl_stage_if.slave bus_if
);
  localparam int unsigned CntW = $clog2(SEQ_CYCLES) + 1;

  localparam logic [3:0] OpLw   = 4'h8;
  localparam logic [3:0] OpSw   = 4'h9;
  localparam logic [3:0] OpLhb  = 4'hA;
  localparam logic [3:0] OpLlb  = 4'hB;
  localparam logic [3:0] OpB    = 4'hC;
  localparam logic [3:0] OpCall = 4'hD;
  localparam logic [3:0] OpRet  = 4'hE;
`ifdef DECODE_HALT_ON_ERR_EN
  localparam logic [3:0] OpErr  = 4'hF;
`endif

  typedef struct packed {
    logic                ctrl_valid;
    logic                data_reg;
    logic                call;
    logic                rtrn;
    logic                branch;
    logic                mem_to_reg;
    logic                reg_to_mem;
    logic                alu_src;
    logic                sign_ext_sel;
    logic                reg_rt_src;
    logic                reg_write;
    logic                seq_last;
    logic                fetch_stall;
    logic [ALU_OP_W-1:0] alu_op;
  } ctrl_t;

`ifdef DECODE_HALT_ON_ERR_EN
  typedef enum logic [1:0] {StDecode, StSeq, StHalt} state_e;
`else
  typedef enum logic [1:0] {StDecode, StSeq} state_e;
`endif

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, cnt_dec;
  logic            is_ret_q, is_ret_d;
  ctrl_t           ctrl_q, ctrl_d, dec;
  logic [3:0]      opcode;
  logic            hold_halt;
  logic            unused_instr;

  assign opcode       = bus_if.instr_in[INSTR_W-1 -: 4];
  assign unused_instr = ^bus_if.instr_in[INSTR_W-5:0];

  // One CALL/RET step; a single-cycle sequence merges the first and last steps.
  function automatic ctrl_t seq_word(logic is_ret, logic first, logic last);
    ctrl_t w;
    w             = '0;
    w.ctrl_valid  = 1'b1;
    w.fetch_stall = 1'b1;
    w.call        = ~is_ret;
    w.rtrn        = is_ret;
    w.reg_to_mem  = first & ~is_ret;
    w.mem_to_reg  = first & is_ret;
    w.reg_write   = last;
    w.seq_last    = last;
    return w;
  endfunction

  always_comb begin
    dec            = '0;
    dec.ctrl_valid = 1'b1;
    if (!opcode[3]) begin
      dec.alu_op    = ALU_OP_W'(opcode[2:0]);
      dec.reg_write = 1'b1;
      if (opcode[2:0] == 3'd4) begin
        dec.alu_src      = 1'b1;
        dec.sign_ext_sel = 1'b1;
      end
    end else begin
      case (opcode)
        OpLw: begin
          dec.data_reg   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_write  = 1'b1;
        end
        OpSw: begin
          dec.data_reg   = 1'b1;
          dec.reg_to_mem = 1'b1;
          dec.alu_src    = 1'b1;
          dec.reg_rt_src = 1'b1;
        end
        OpLhb, OpLlb: begin
          dec.reg_write = 1'b1;
          dec.alu_op    = ALU_OP_W'(opcode[2:0]);
        end
        OpB:     dec.branch = 1'b1;
        OpCall:  dec = seq_word(1'b0, 1'b1, SEQ_CYCLES == 1);
        OpRet:   dec = seq_word(1'b1, 1'b1, SEQ_CYCLES == 1);
        default: ; // ERR without halt support is a valid NOP
      endcase
    end
  end

`ifdef DECODE_HALT_ON_ERR_EN
  logic halted_q, halted_d;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_ret_d  = is_ret_q;
    ctrl_d    = ctrl_q;
    hold_halt = 1'b0;
    cnt_dec   = (cnt_q != '0) ? cnt_q - CntW'(1) : '0;
`ifdef DECODE_HALT_ON_ERR_EN
    halted_d  = halted_q;
    hold_halt = (state_q == StHalt);
`endif
    if (!hold_halt) begin
      if (bus_if.flush) begin
        ctrl_d  = '0;
        state_d = StDecode;
        cnt_d   = '0;
      end else if (!bus_if.stall_in) begin
        case (state_q)
          StDecode: begin
            if (!bus_if.instr_valid) begin
              ctrl_d = '0;
`ifdef DECODE_HALT_ON_ERR_EN
            end else if (opcode == OpErr) begin
              ctrl_d             = '0;
              ctrl_d.fetch_stall = 1'b1;
              halted_d           = 1'b1;
              state_d            = StHalt;
`endif
            end else begin
              ctrl_d = dec;
              if ((opcode == OpCall || opcode == OpRet) && SEQ_CYCLES > 1) begin
                is_ret_d = (opcode == OpRet);
                cnt_d    = CntW'(SEQ_CYCLES - 1);
                state_d  = StSeq;
              end
            end
          end
          StSeq: begin
            cnt_d  = cnt_dec;
            ctrl_d = seq_word(is_ret_q, 1'b0, cnt_dec == '0);
            if (cnt_dec == '0) state_d = StDecode;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StDecode;
      cnt_q    <= '0;
      is_ret_q <= 1'b0;
      ctrl_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_ret_q <= is_ret_d;
      ctrl_q   <= ctrl_d;
    end
  end

`ifdef DECODE_HALT_ON_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
  assign bus_if.halted = halted_q;
`else
  assign bus_if.halted = 1'b0;
`endif

  assign bus_if.fetch_stall  = ctrl_q.fetch_stall;
  assign bus_if.ctrl_valid   = ctrl_q.ctrl_valid;
  assign bus_if.data_reg     = ctrl_q.data_reg;
  assign bus_if.call         = ctrl_q.call;
  assign bus_if.rtrn         = ctrl_q.rtrn;
  assign bus_if.branch       = ctrl_q.branch;
  assign bus_if.mem_to_reg   = ctrl_q.mem_to_reg;
  assign bus_if.reg_to_mem   = ctrl_q.reg_to_mem;
  assign bus_if.alu_src      = ctrl_q.alu_src;
  assign bus_if.sign_ext_sel = ctrl_q.sign_ext_sel;
  assign bus_if.reg_rt_src   = ctrl_q.reg_rt_src;
  assign bus_if.reg_write    = ctrl_q.reg_write;
  assign bus_if.seq_last     = ctrl_q.seq_last;
  assign bus_if.alu_op       = ctrl_q.alu_op;
endmodule

// File: tb/tb_decode_ctrl_stage.sv
// Directed bench for decode_ctrl_stage: three instances (SEQ_CYCLES 3, 2, 1) share one stimulus.
// Honours DECODE_HALT_ON_ERR_EN for the ERR checks.
module tb_decode_ctrl_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        valid, stall, flush;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // Observed word: {valid,dreg,call,rtrn,br,m2r,r2m,asrc,sext,rtsrc,rw,last,fstall,halted,alu_op}
  localparam logic [16:0] V  = 17'd1 << 16;
  localparam logic [16:0] DR = 17'd1 << 15;
  localparam logic [16:0] CA = 17'd1 << 14;
  localparam logic [16:0] RT = 17'd1 << 13;
  localparam logic [16:0] BR = 17'd1 << 12;
  localparam logic [16:0] MR = 17'd1 << 11;
  localparam logic [16:0] RM = 17'd1 << 10;
  localparam logic [16:0] AS = 17'd1 << 9;
  localparam logic [16:0] SE = 17'd1 << 8;
  localparam logic [16:0] RS = 17'd1 << 7;
  localparam logic [16:0] RW = 17'd1 << 6;
  localparam logic [16:0] SL = 17'd1 << 5;
  localparam logic [16:0] FS = 17'd1 << 4;
  localparam logic [16:0] HA = 17'd1 << 3;

  decode_ctrl_stage_if #(.INSTR_W(16), .ALU_OP_W(3)) if3 ();
  decode_ctrl_stage_if #(.INSTR_W(16), .ALU_OP_W(3)) if2 ();
  decode_ctrl_stage_if #(.INSTR_W(16), .ALU_OP_W(3)) if1 ();

  decode_ctrl_stage #(.INSTR_W(16), .ALU_OP_W(3), .SEQ_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .bus_if(if3)
  );
  decode_ctrl_stage #(.INSTR_W(16), .ALU_OP_W(3), .SEQ_CYCLES(2)) u_dut2 (
    .clk(clk), .rst(rst), .bus_if(if2)
  );
  decode_ctrl_stage #(.INSTR_W(16), .ALU_OP_W(3), .SEQ_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .bus_if(if1)
  );

  assign if3.instr_in = instr;
  assign if3.instr_valid = valid;
  assign if3.stall_in = stall;
  assign if3.flush = flush;
  assign if2.instr_in = instr;
  assign if2.instr_valid = valid;
  assign if2.stall_in = stall;
  assign if2.flush = flush;
  assign if1.instr_in = instr;
  assign if1.instr_valid = valid;
  assign if1.stall_in = stall;
  assign if1.flush = flush;

  logic [16:0] w3, w2, w1;
  assign w3 = {if3.ctrl_valid, if3.data_reg, if3.call, if3.rtrn, if3.branch, if3.mem_to_reg,
               if3.reg_to_mem, if3.alu_src, if3.sign_ext_sel, if3.reg_rt_src, if3.reg_write,
               if3.seq_last, if3.fetch_stall, if3.halted, if3.alu_op};
  assign w2 = {if2.ctrl_valid, if2.data_reg, if2.call, if2.rtrn, if2.branch, if2.mem_to_reg,
               if2.reg_to_mem, if2.alu_src, if2.sign_ext_sel, if2.reg_rt_src, if2.reg_write,
               if2.seq_last, if2.fetch_stall, if2.halted, if2.alu_op};
  assign w1 = {if1.ctrl_valid, if1.data_reg, if1.call, if1.rtrn, if1.branch, if1.mem_to_reg,
               if1.reg_to_mem, if1.alu_src, if1.sign_ext_sel, if1.reg_rt_src, if1.reg_write,
               if1.seq_last, if1.fetch_stall, if1.halted, if1.alu_op};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; instr = '0; valid = 1'b0; stall = 1'b0; flush = 1'b0;
    tick(); tick();
    chk("reset3", w3, '0);
    chk("reset2", w2, '0);
    chk("reset1", w1, '0);
    rst = 1'b0;

    valid = 1'b1; instr = 16'h0123; tick(); chk("add", w3, V | RW);
    instr = 16'h1ABC; tick(); chk("sub", w3, V | RW | 17'd1);
    instr = 16'h3000; tick(); chk("xor", w3, V | RW | 17'd3);
    instr = 16'h4000; tick(); chk("inc", w3, V | RW | AS | SE | 17'd4);
    instr = 16'h7000; tick(); chk("sll", w3, V | RW | 17'd7);
    instr = 16'h8000; tick(); chk("lw", w3, V | DR | MR | AS | RW);
    instr = 16'hA000; tick(); chk("lhb", w3, V | RW | 17'd2);
    instr = 16'hB000; tick(); chk("llb", w3, V | RW | 17'd3);
    instr = 16'hC000; tick(); chk("b", w3, V | BR);
    valid = 1'b0; tick(); chk("bubble", w3, '0);

    // SW held back by a 3-cycle stall
    valid = 1'b1; instr = 16'h9123; stall = 1'b1;
    tick(); chk("stall1", w3, '0);
    tick(); chk("stall2", w3, '0);
    tick(); chk("stall3", w3, '0);
    stall = 1'b0; tick(); chk("sw", w3, V | DR | RM | AS | RS);
    stall = 1'b1; instr = 16'h0123; tick(); chk("sw_hold", w3, V | DR | RM | AS | RS);
    stall = 1'b0;

    // CALL across all three sequence lengths; ADD offered during the sequence
    instr = 16'hD000; tick();
    chk("call3_s0", w3, V | CA | RM | FS);
    chk("call2_s0", w2, V | CA | RM | FS);
    chk("call1_s0", w1, V | CA | RM | RW | SL | FS);
    instr = 16'h0123; tick();
    chk("call3_s1", w3, V | CA | FS);
    chk("call2_s1", w2, V | CA | RW | SL | FS);
    chk("call1_next", w1, V | RW);
    tick();
    chk("call3_s2", w3, V | CA | RW | SL | FS);
    chk("call2_next", w2, V | RW);
    tick(); chk("call3_next", w3, V | RW);

    // RET aborted by flush on its second step
    instr = 16'hE000; tick(); chk("ret2_s0", w2, V | RT | MR | FS);
    valid = 1'b0; flush = 1'b1; tick();
    chk("ret2_flush", w2, '0);
    chk("ret3_flush", w3, '0);
    flush = 1'b0; valid = 1'b1; instr = 16'h0123; tick();
    chk("ret2_resume", w2, V | RW);
    chk("ret3_resume", w3, V | RW);

    // Flush beats stall and a valid instruction
    instr = 16'h1000; stall = 1'b1; flush = 1'b1; tick(); chk("flush_prio", w3, '0);
    stall = 1'b0; flush = 1'b0; tick(); chk("post_flush", w3, V | RW | 17'd1);

    // Reset in the middle of a CALL sequence
    instr = 16'hD000; tick(); chk("call_rst_s0", w3, V | CA | RM | FS);
    rst = 1'b1; valid = 1'b0; tick(); chk("rst_mid_seq", w3, '0);
    rst = 1'b0; tick(); chk("rst_no_steps", w3, '0);

    // ERR
    valid = 1'b1; instr = 16'hF000; tick();
`ifdef DECODE_HALT_ON_ERR_EN
    chk("err_halt", w3, FS | HA);
    instr = 16'h0123; flush = 1'b1; tick(); chk("halt_flush", w3, FS | HA);
    flush = 1'b0; tick(); chk("halt_hold", w3, FS | HA);
    rst = 1'b1; tick(); chk("halt_rst", w3, '0);
    rst = 1'b0; tick(); chk("after_halt", w3, V | RW);
`else
    chk("err_nop", w3, V);
    instr = 16'h0123; tick(); chk("after_err", w3, V | RW);
`endif
    valid = 1'b0; tick(); chk("final_bubble", w3, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/decode_ctrl_stage.md
# decode_ctrl_stage

Registered, parametrised instruction-decode control stage for the WISC pipeline. It decodes the 4-bit opcode of each fetched instruction into the datapath control word and registers it into the ID/EX boundary. It supports pipeline stall and flush, sequences CALL/RET over a configurable number of cycles while holding fetch, and optionally halts on the ERR opcode.

## Interface
- `INSTR_W`, 16: instruction width; the opcode is `instr_in[INSTR_W-1 -: 4]`.
- `ALU_OP_W`, 3: width of `alu_op`; must be ≥3; ALU codes are zero-extended.
- `SEQ_CYCLES`, 2: cycles a CALL or RET occupies; legal range 1..8.

Ports. One clock; reset is synchronous and active-high (`rst`, sampled on the rising edge of `clk`).
- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `instr_in`  in  INSTR_W  instruction from IF/ID
- `instr_valid`  in  1  `instr_in` is valid this cycle
- `stall_in`  in  1  downstream hazard: hold all state and outputs
- `flush`  in  1  squash the current/in-flight instruction
- `fetch_stall`  out  1  IF must hold PC and instruction
- `ctrl_valid`  out  1  registered control word is valid
- `data_reg`, `call`, `rtrn`, `branch`, `mem_to_reg`, `reg_to_mem`, `alu_src`, `sign_ext_sel`, `reg_rt_src`, `reg_write`  out  1 each  registered controls
- `alu_op`  out  ALU_OP_W  registered ALU operation
- `seq_last`  out  1  current control word is the final step of CALL/RET
- `halted`  out  1  core halted (ERR decoded, macro enabled)

## Operation
- Opcode map: ADD 0, SUB 1, NAND 2, XOR 3, INC 4, SRA 5, SRL 6, SLL 7, LW 8, SW 9, LHB A, LLB B, B C, CALL D, RET E, ERR F.
- Opcodes 0–7: `alu_op = opcode[2:0]` and `reg_write = 1`. INC additionally drives `alu_src = 1` and `sign_ext_sel = 1`.
- LW: `data_reg`, `mem_to_reg`, `alu_src`, `reg_write` = 1; `alu_op = 0`.
- SW: `data_reg`, `reg_to_mem`, `alu_src`, `reg_rt_src` = 1; `alu_op = 0`.
- LHB/LLB: `reg_write = 1`; `alu_op = opcode[2:0]`.
- B: `branch = 1`; `alu_op = 0`.
- Any control not listed for an opcode is 0. `alu_op` is never X or Z.
- State machine, states DECODE, SEQ, HALT:
  - DECODE: if `instr_valid & ~stall_in & ~flush`, register the decoded word and set `ctrl_valid = 1`; otherwise, when not stalled, register an all-zero bubble.
  - DECODE, CALL/RET with `SEQ_CYCLES > 1`: go to SEQ and load `cnt = SEQ_CYCLES-1`.
  - SEQ: `instr_valid` is ignored. Each unstalled cycle decrements `cnt` and emits the next step. Return to DECODE after the step with `cnt == 0`.
  - HALT: absorbing; left only by `rst`.
- CALL steps:
  - Step 0: `call`, `reg_to_mem` = 1 (push return address).
  - Last step: `call`, `reg_write`, `seq_last` = 1 (SP/PC update).
  - Middle steps: `call = 1` only.
- RET steps:
  - Step 0: `rtrn`, `mem_to_reg` = 1.
  - Last step: `rtrn`, `reg_write`, `seq_last` = 1.
  - Middle steps: `rtrn = 1` only.
- CALL/RET with `SEQ_CYCLES == 1`: one word is emitted that is the union of step 0 and the last step, with `seq_last = 1`.
- `alu_op = 0` for all CALL/RET steps. `ctrl_valid = 1` on every step.
- `fetch_stall` is high from the cycle step 0 is registered until the cycle the last step is registered, inclusive.

## Timing
- Reset: all outputs 0, state DECODE, `cnt = 0`.
- Latency: 1 cycle. An instruction accepted at edge N has its control word on the outputs after edge N.
- `stall_in = 1`: state, `cnt` and all outputs hold; `flush` is still honoured.
- `flush = 1`: next edge registers a bubble (`ctrl_valid = 0`, all controls 0), clears `fetch_stall`, and aborts SEQ to DECODE. `flush` has priority over `stall_in` and over a new `instr_valid`.
- `flush` in HALT has no effect.
- `rst` mid-SEQ: abandon the sequence with no further steps; outputs go to reset values on that edge.
- `cnt` is `$clog2(SEQ_CYCLES)+1` bits wide and never wraps below 0.

## Configuration
- `DECODE_HALT_ON_ERR_EN` defined: ERR accepted in DECODE registers a bubble, sets `halted = 1`, enters HALT, and holds `fetch_stall = 1` permanently until reset.
- Undefined: ERR decodes as a NOP bubble with `ctrl_valid = 1` and all controls 0; `halted` is tied to 0 and the HALT state is not built.

## Test plan
- Reset then ADD (0x0123) valid: one cycle later, `ctrl_valid = 1`, `alu_op = 0`, `reg_write = 1`, all other controls 0.
- SW (0x9xxx) with `stall_in` high for 3 cycles: outputs unchanged across the stall, then the SW word with `reg_to_mem = 1`, `reg_rt_src = 1`, `alu_src = 1`.
- CALL (0xDxxx), `SEQ_CYCLES = 3`:
  - Steps observed: {`call`, `reg_to_mem`}, then {`call`}, then {`call`, `reg_write`, `seq_last`}.
  - `fetch_stall` is high for exactly 3 cycles.
  - An `instr_valid` presented during SEQ is ignored.
- RET, `SEQ_CYCLES = 2`, `flush` asserted on step 1: bubble registered, `fetch_stall` drops, next instruction decodes normally.
- ERR (0xF000):
  - With `DECODE_HALT_ON_ERR_EN` defined: `halted = 1` and `fetch_stall = 1` persist through `flush`; `rst` clears both.
  - Without the macro: a single bubble with `ctrl_valid = 1`, and decoding continues.
- CALL with `SEQ_CYCLES = 1`: single word {`call`, `reg_to_mem`, `reg_write`, `seq_last`}, with `fetch_stall` high for 1 cycle.
